dmem_responder: RTL and testbench

- Data-memory target that answers the pipeline's MEM-stage load/store requests.
- Replaces the single-cycle data memory with a wait-stated responder.
- Drives `stall_o` back to the pipeline, which freezes PC, IF/ID, ID/EX, EX/MEM and MEM/WB while an access is pending.
- Completes each access with a one-cycle `done_o` pulse and registered read data.

---
 rtl/dmem_pkg.sv | 25 ++
 rtl/dmem_array.sv | 100 ++++++++++
 rtl/dmem_responder.sv | 185 ++++++++++++++++++
 tb/tb_dmem_responder.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the wait-stated data-memory responder.
// Optional parity storage is enabled with the DMEM_PARITY_EN macro.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [2:0] ERR_NONE   = 3'd0;
  localparam logic [2:0] ERR_ALIGN  = 3'd1;
  localparam logic [2:0] ERR_RANGE  = 3'd2;
  localparam logic [2:0] ERR_BOTH   = 3'd3;
  localparam logic [2:0] ERR_PARITY = 3'd4;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 16;

  // Address faults encode as a bitmask so misaligned+out-of-range lands on ERR_BOTH.
  function automatic logic [2:0] addr_cause(input logic misaligned, input logic out_of_range);
    return {1'b0, out_of_range, misaligned};
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage with synchronous write, asynchronous read and a sequential
// post-reset clear engine; DMEM_PARITY_EN adds a per-word even-parity bit.
module dmem_array import dmem_pkg::*; #(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int DEPTH_WORDS = 256,
  localparam int AW         = $clog2(DEPTH_WORDS)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
`ifdef DMEM_PARITY_EN
  input  logic              inject_par_i,
`endif
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              par_err_o,
  output logic              clearing_o
);

  localparam logic [AW-1:0] IDX_ONE  = AW'(1);
  localparam logic [AW-1:0] IDX_LAST = AW'(DEPTH_WORDS - 1);

  logic [DATA_W-1:0] mem_q [DEPTH_WORDS];

  logic              clr_active_q, clr_active_d;
  logic [AW-1:0]     clr_idx_q, clr_idx_d;

  logic              mem_we;
  logic [AW-1:0]     mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  always_comb begin
    clr_active_d = clr_active_q;
    clr_idx_d    = clr_idx_q;
    if (clr_active_q) begin
      clr_idx_d = clr_idx_q + IDX_ONE;
      if (clr_idx_q == IDX_LAST) begin
        clr_active_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      clr_active_q <= 1'b1;
      clr_idx_q    <= '0;
    end else begin
      clr_active_q <= clr_active_d;
      clr_idx_q    <= clr_idx_d;
    end
  end

  // The clear engine owns the write port; user writes are dropped during reset.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = waddr_i;
    mem_wdata = wdata_i;
    if (clr_active_q) begin
      mem_we    = 1'b1;
      mem_waddr = clr_idx_q;
      mem_wdata = '0;
    end else if (we_i && !rst_i) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign rdata_o    = mem_q[raddr_i];
  assign clearing_o = clr_active_q;

`ifdef DMEM_PARITY_EN
  logic par_q [DEPTH_WORDS];
  logic par_wbit;

  always_comb begin
    par_wbit = 1'b0;
    if (!clr_active_q) begin
      par_wbit = (^wdata_i) ^ inject_par_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      par_q[mem_waddr] <= par_wbit;
    end
  end

  assign par_err_o = (^rdata_o) ^ par_q[raddr_i];
`else
  assign par_err_o = 1'b0;
`endif

endmodule

// File: rtl/dmem_responder.sv
// Wait-stated MEM-stage data-memory responder: stalls the pipeline, then
// completes each load/store with a done_o pulse. Parity: DMEM_PARITY_EN.
module dmem_responder import dmem_pkg::*; #(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] data_i,
`ifdef DMEM_PARITY_EN
  input  logic              inject_par_i,
`endif
  output logic [DATA_W-1:0] data_o,
  output logic              stall_o,
  output logic              done_o,
  output logic              err_o
);

  localparam int         AW        = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  // rst_n is active-high; the name is kept for port compatibility.
  logic rst;
  assign rst = rst_n;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              idle, req, clearing, load_resp;
  logic [ADDR_W-1:0] acc_addr;
  logic              acc_rd, acc_wr;
  logic              misaligned, out_of_range, addr_ok, is_load, collision;
  logic [2:0]        cause;
  logic              mem_we, par_err;
  logic [DATA_W-1:0] rdata;

  assign idle = (state_q == IDLE);
  assign req  = MemRead_i | MemWrite_i;

  // In IDLE the access is judged on the live inputs so a zero-wait response
  // can be formed in the request cycle; afterwards the latched copy is used.
  assign acc_addr = idle ? addr_i     : addr_q;
  assign acc_rd   = idle ? MemRead_i  : rd_q;
  assign acc_wr   = idle ? MemWrite_i : wr_q;

  assign misaligned   = acc_addr[0];
  assign out_of_range = |acc_addr[ADDR_W-1:AW+1];
  assign addr_ok      = !misaligned && !out_of_range;
  assign is_load      = acc_rd && !acc_wr;
  assign collision    = acc_rd && acc_wr;

  always_comb begin
    cause = addr_cause(misaligned, out_of_range);
    if (addr_ok && is_load && par_err) begin
      cause = ERR_PARITY;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    data_d    = data_q;
    err_d     = err_q;
    done_d    = 1'b0;
    load_resp = 1'b0;
    case (state_q)
      IDLE: begin
        if (req && !clearing) begin
          addr_d  = addr_i;
          wdata_d = data_i;
          rd_d    = MemRead_i;
          wr_d    = MemWrite_i;
          if (WAIT_CYCLES == 0) begin
            state_d   = RESP;
            load_resp = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = WAIT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d   = RESP;
          load_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (load_resp) begin
      done_d = 1'b1;
      data_d = (addr_ok && is_load) ? rdata : '0;
      err_d  = (cause != ERR_NONE) || collision;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      data_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      data_q  <= data_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // The store lands at the end of RESP, just as the pipeline advances.
  assign mem_we = (state_q == RESP) && wr_q && addr_ok;

`ifdef DMEM_PARITY_EN
  logic inj_pend_q, inj_pend_d;

  always_comb begin
    inj_pend_d = inj_pend_q | inject_par_i;
    if (mem_we) begin
      inj_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst) begin
      inj_pend_q <= 1'b0;
    end else begin
      inj_pend_q <= inj_pend_d;
    end
  end
`endif

  dmem_array #(
    .DATA_W      (DATA_W),
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_array (
    .clk_i        (clk_i),
    .rst_i        (rst),
    .we_i         (mem_we),
    .waddr_i      (addr_q[AW:1]),
    .wdata_i      (wdata_q),
`ifdef DMEM_PARITY_EN
    .inject_par_i (inj_pend_q | inject_par_i),
`endif
    .raddr_i      (acc_addr[AW:1]),
    .rdata_o      (rdata),
    .par_err_o    (par_err),
    .clearing_o   (clearing)
  );

  assign stall_o = clearing || (state_q == WAIT) || (idle && req);
  assign data_o  = data_q;
  assign done_o  = done_q;
  assign err_o   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a WAIT_CYCLES=2 instance and a
// WAIT_CYCLES=0 instance sharing stimulus, gated by a select.
`timescale 1ns/1ps
module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, rd, wr, sel;
  logic [15:0] addr, wdata;
  logic        rd2, wr2, rd0, wr0;
  logic [15:0] q2, q0, q;
  logic        st2, st0, dn2, dn0, er2, er0;
  logic        stall, done, err;
`ifdef DMEM_PARITY_EN
  logic        inj = 1'b0;
`endif

  assign rd2   = rd & ~sel;
  assign wr2   = wr & ~sel;
  assign rd0   = rd & sel;
  assign wr0   = wr & sel;
  assign q     = sel ? q0  : q2;
  assign stall = sel ? st0 : st2;
  assign done  = sel ? dn0 : dn2;
  assign err   = sel ? er0 : er2;

  dmem_responder #(.DATA_W(16), .ADDR_W(16), .DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut (
    .clk_i(clk), .rst_n(rst), .MemRead_i(rd2), .MemWrite_i(wr2),
    .addr_i(addr), .data_i(wdata),
`ifdef DMEM_PARITY_EN
    .inject_par_i(inj),
`endif
    .data_o(q2), .stall_o(st2), .done_o(dn2), .err_o(er2));

  dmem_responder #(.DATA_W(16), .ADDR_W(16), .DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut0 (
    .clk_i(clk), .rst_n(rst), .MemRead_i(rd0), .MemWrite_i(wr0),
    .addr_i(addr), .data_i(wdata),
`ifdef DMEM_PARITY_EN
    .inject_par_i(1'b0),
`endif
    .data_o(q0), .stall_o(st0), .done_o(dn0), .err_o(er0));

  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Called just after a posedge; returns just after the edge that ends RESP.
  task automatic access(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d,
                        output logic e, output logic [15:0] dq,
                        output int stalls, output int lat, output int done_at);
    bit got;
    got = 0;
    rd = r; wr = w; addr = a; wdata = d;
    stalls = 0; lat = 0; e = 1'b0; dq = 16'h0; done_at = -1;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (stall) stalls++;
      if (done) begin
        got = 1; e = err; dq = q; done_at = cyc_n;
      end
      @(posedge clk); #1;
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL access_timeout: addr 0x%0h got no done in 40 cycles, expected done", a);
    end
  endtask

  task automatic go_idle();
    rd = 1'b0; wr = 1'b0;
    @(negedge clk);
    check("done_single_pulse", {31'd0, done}, 32'd0);
    check("idle_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
  endtask

  // Waits for both instances to finish clearing; counts any stray done pulse.
  task automatic wait_clear(output int stray_done);
    int n;
    n = 0; stray_done = 0;
    while ((st2 || st0) && n < 600) begin
      @(negedge clk);
      if (dn2 || dn0) stray_done++;
      @(posedge clk); #1;
      n++;
    end
    if (st2 || st0) begin
      checks++; errors++;
      $display("FAIL clear_timeout: stall still 1 after %0d cycles, expected 0", n);
    end
  endtask

  typedef struct {
    logic        r;
    logic        w;
    logic [15:0] a;
    logic [15:0] d;
    logic        e_err;
    logic [15:0] e_data;
    logic        chk_data;
    string       nm;
  } vec_t;

  vec_t vecs[$];

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        e;
    logic [15:0] dq;
    int          stalls, lat, dat, dat_a, stray;

    rst = 1'b1; rd = 1'b0; wr = 1'b0; sel = 1'b0; addr = 16'h0; wdata = 16'h0;

    //                 r     w     addr      wdata     err   data      chk
    vecs.push_back('{1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'h0000, 1'b1, "ld_0010_cleared"});
    vecs.push_back('{1'b0, 1'b1, 16'h0004, 16'hBEEF, 1'b0, 16'h0000, 1'b0, "st_0004_beef"});
    vecs.push_back('{1'b1, 1'b0, 16'h0004, 16'h0000, 1'b0, 16'hBEEF, 1'b1, "ld_0004_raw"});
    vecs.push_back('{1'b1, 1'b0, 16'h0005, 16'h0000, 1'b1, 16'h0000, 1'b1, "ld_0005_misaligned"});
    vecs.push_back('{1'b0, 1'b1, 16'h0200, 16'h1234, 1'b1, 16'h0000, 1'b1, "st_0200_range"});
    vecs.push_back('{1'b1, 1'b0, 16'h0004, 16'h0000, 1'b0, 16'hBEEF, 1'b1, "ld_0004_unchanged"});
    vecs.push_back('{1'b0, 1'b1, 16'h01FE, 16'hCAFE, 1'b0, 16'h0000, 1'b0, "st_01fe_last"});
    vecs.push_back('{1'b1, 1'b0, 16'h01FE, 16'h0000, 1'b0, 16'hCAFE, 1'b1, "ld_01fe_last"});
    vecs.push_back('{1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b1, "ld_0000_no_alias"});
    vecs.push_back('{1'b1, 1'b1, 16'h0006, 16'h7777, 1'b1, 16'h0000, 1'b0, "rdwr_0006_collision"});
    vecs.push_back('{1'b1, 1'b0, 16'h0006, 16'h0000, 1'b0, 16'h7777, 1'b1, "ld_0006_after_coll"});
    vecs.push_back('{1'b0, 1'b1, 16'h0007, 16'h9999, 1'b1, 16'h0000, 1'b1, "st_0007_misaligned"});
    vecs.push_back('{1'b1, 1'b0, 16'h0006, 16'h0000, 1'b0, 16'h7777, 1'b1, "ld_0006_intact"});
    vecs.push_back('{1'b1, 1'b0, 16'hFFFE, 16'h0000, 1'b1, 16'h0000, 1'b1, "ld_fffe_range"});
    vecs.push_back('{1'b0, 1'b1, 16'h0004, 16'h1357, 1'b0, 16'h0000, 1'b0, "st_0004_overwrite"});
    vecs.push_back('{1'b1, 1'b0, 16'h0004, 16'h0000, 1'b0, 16'h1357, 1'b1, "ld_0004_new"});

    // Reset and clear
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_done", {31'd0, dn2}, 32'd0);
    check("rst_err", {31'd0, er2}, 32'd0);
    check("rst_data", {16'd0, q2}, 32'd0);
    check("rst_data_w0", {16'd0, q0}, 32'd0);
    check("clear_stall", {31'd0, st2}, 32'd1);
    wait_clear(stray);
    check("clear_no_done", stray, 0);
    check("idle_stall_after_clear", {31'd0, st2}, 32'd0);

    // Table, back-to-back on the WAIT_CYCLES=2 instance
    for (int i = 0; i < vecs.size(); i++) begin
      access(vecs[i].r, vecs[i].w, vecs[i].a, vecs[i].d, e, dq, stalls, lat, dat);
      check({vecs[i].nm, "_stalls"}, stalls, 3);
      check({vecs[i].nm, "_latency"}, lat, 4);
      check({vecs[i].nm, "_err"}, {31'd0, e}, {31'd0, vecs[i].e_err});
      if (vecs[i].chk_data) check({vecs[i].nm, "_data"}, {16'd0, dq}, {16'd0, vecs[i].e_data});
    end
    go_idle();
    check("data_held_after_done", {16'd0, q2}, 32'h1357);

    // Reset while a store sits in WAIT
    rd = 1'b0; wr = 1'b1; addr = 16'h0008; wdata = 16'h5A5A;
    @(negedge clk);
    check("abort_req_stall", {31'd0, st2}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b1; rd = 1'b0; wr = 1'b0;
    @(negedge clk);
    stray = dn2 ? 1 : 0;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_data_reset", {16'd0, q2}, 32'd0);
    check("abort_done_reset", {31'd0, dn2}, 32'd0);
    wait_clear(dat);
    check("abort_no_done", stray + dat, 0);
    access(1'b1, 1'b0, 16'h0008, 16'h0, e, dq, stalls, lat, dat);
    check("abort_ld_0008_data", {16'd0, dq}, 32'd0);
    check("abort_ld_0008_err", {31'd0, e}, 32'd0);
    go_idle();

    // WAIT_CYCLES=0 instance, back-to-back stores then loads
    sel = 1'b1;
    access(1'b0, 1'b1, 16'h0000, 16'h1111, e, dq, stalls, lat, dat_a);
    check("w0_st0_stalls", stalls, 1);
    check("w0_st0_latency", lat, 2);
    check("w0_st0_err", {31'd0, e}, 32'd0);
    access(1'b0, 1'b1, 16'h0002, 16'h2222, e, dq, stalls, lat, dat);
    check("w0_st1_stalls", stalls, 1);
    check("w0_done_spacing", dat - dat_a, 2);
    access(1'b1, 1'b0, 16'h0000, 16'h0, e, dq, stalls, lat, dat);
    check("w0_ld_0000", {16'd0, dq}, 32'h1111);
    access(1'b1, 1'b0, 16'h0002, 16'h0, e, dq, stalls, lat, dat);
    check("w0_ld_0002", {16'd0, dq}, 32'h2222);
    check("w0_ld_0002_err", {31'd0, e}, 32'd0);
    access(1'b1, 1'b0, 16'h0003, 16'h0, e, dq, stalls, lat, dat);
    check("w0_ld_0003_err", {31'd0, e}, 32'd1);
    check("w0_ld_0003_data", {16'd0, dq}, 32'd0);
    go_idle();
    sel = 1'b0;

`ifdef DMEM_PARITY_EN
    inj = 1'b1;
    access(1'b0, 1'b1, 16'h0010, 16'h00FF, e, dq, stalls, lat, dat);
    inj = 1'b0;
    check("par_st_err", {31'd0, e}, 32'd0);
    access(1'b1, 1'b0, 16'h0010, 16'h0, e, dq, stalls, lat, dat);
    check("par_ld_data", {16'd0, dq}, 32'h00FF);
    check("par_ld_err", {31'd0, e}, 32'd1);
    access(1'b1, 1'b0, 16'h0004, 16'h0, e, dq, stalls, lat, dat);
    check("par_untouched_err", {31'd0, e}, 32'd0);
    access(1'b0, 1'b1, 16'h0010, 16'h00FF, e, dq, stalls, lat, dat);
    access(1'b1, 1'b0, 16'h0010, 16'h0, e, dq, stalls, lat, dat);
    check("par_rewrite_err", {31'd0, e}, 32'd0);
    go_idle();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
